// File: rtl/fetch_decode_buf_if.sv
// Fetch/bus/decode signal bundle for fetch_decode_buf.
// slave is the buffer's view; master is the fetch/bus/decode environment's view.
interface fetch_decode_buf_if;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  logic        req_valid;
  logic [31:0] pcF;
  ibus_resp_t  iresp;
  logic        stallD;
  logic        flush;
  logic        stall_fetch;
  logic        validD;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  modport slave (
    input  req_valid, pcF, iresp, stallD, flush,
    output stall_fetch, validD, pcD, instrD, perf_fetched, perf_bubbles
  );

  modport master (
    output req_valid, pcF, iresp, stallD, flush,
    input  stall_fetch, validD, pcD, instrD, perf_fetched, perf_bubbles
  );
endinterface

// File: rtl/fetch_decode_buf.sv
// Fetch-to-decode buffer: tracks one outstanding ibus request, pairs data with its PC, 2-entry FIFO to decode.
// Optional perf counters under `define FDBUF_PERF_EN; otherwise perf ports read 0.
module fetch_decode_buf #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input logic                clk,
  input logic                resetn,
  fetch_decode_buf_if.slave  bus
);
  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  count, count_nxt;
  logic        rd_ptr, wr_ptr;
  logic [31:0] pend_pc;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        stall_q;

  logic        fire, push, push_ok, pop, validd;
  logic [31:0] push_pc;

  assign validd = (count != 2'd0);

  always_comb begin
    fire      = bus.req_valid & bus.iresp.addr_ok;
    state_nxt = state;
    push      = 1'b0;
    push_pc   = bus.pcF;
    case (state)
      S_IDLE: begin
        if (fire) begin
          if (bus.iresp.data_ok) push = 1'b1;
          // a request issued during flush used the stale pcF, so its data is unwanted
          else state_nxt = bus.flush ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.iresp.data_ok) begin
          push      = 1'b1;
          push_pc   = pend_pc;
          state_nxt = S_IDLE;
        end else if (bus.flush) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.iresp.data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    push_ok   = push & ~bus.flush;
    pop       = validd & ~bus.stallD & ~bus.flush;
    count_nxt = bus.flush ? 2'd0 : count + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      pend_pc <= 32'd0;
      stall_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= RESET_PC;
        fifo_instr[i] <= 32'd0;
      end
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      stall_q <= (state_nxt != S_IDLE) | (count_nxt == FULL);
      if (state == S_IDLE && fire) pend_pc <= bus.pcF;
      if (bus.flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push_ok) begin
          fifo_pc[wr_ptr]    <= push_pc;
          fifo_instr[wr_ptr] <= bus.iresp.data;
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  assign bus.stall_fetch = stall_q;
  assign bus.validD      = validd;
  assign bus.pcD         = fifo_pc[rd_ptr];
  assign bus.instrD      = fifo_instr[rd_ptr];

`ifdef FDBUF_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      if (push_ok) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!validd) perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`else
  assign bus.perf_fetched = 32'd0;
  assign bus.perf_bubbles = 32'd0;
`endif
endmodule

// File: doc/fetch_decode_buf.md
# fetch_decode_buf

Fetch-to-decode boundary buffer for the 5-stage MIPS core. Tracks the single outstanding instruction-bus request issued by the fetch stage, pairs each returned word with the PC that requested it, and queues pairs in a 2-entry FIFO read by decode. Owns the fetch stall that limits in-flight requests, and discards stale responses after a pipeline flush.

## Interface
Parameters:
- DEPTH, 2: FIFO entries. Only 2 is supported.
- RESET_PC, 32'hbfc0_0000: reset value of pcD.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch is driving a request this cycle (ireq.valid).
- pcF  in  32  address of the current request (ireq.addr).
- iresp  in  ibus_resp_t  bus response; uses addr_ok, data_ok and data[31:0].
- stallD  in  1  decode cannot accept an instruction this cycle.
- flush  in  1  redirect/exception; kill everything buffered and in flight.
- stall_fetch  out  1  fetch must hold pcF and drop req_valid.
- validD  out  1  pcD/instrD hold a live instruction.
- pcD  out  32  PC of the head entry.
- instrD  out  32  instruction word of the head entry.
- perf_fetched  out  32  count of pushed instructions (see Configuration).
- perf_bubbles  out  32  count of cycles with validD=0 (see Configuration).

## Operation
- Request fire: fire = req_valid & iresp.addr_ok. On fire, pcF is latched into pend_pc.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, result wanted.
  - DROP: one request outstanding, result to be discarded.
- IDLE:
  - fire & data_ok in the same cycle: push {pcF, data}; stay IDLE.
  - fire without data_ok: go to WAIT.
- WAIT:
  - data_ok: push {pend_pc, data}; go to IDLE.
  - Otherwise hold.
- DROP:
  - data_ok: discard the data; go to IDLE.
- stall_fetch = (state != IDLE) | (count == 2). The signal depends only on registers, and it guarantees that count plus outstanding requests never exceeds 2.
- Pop: when validD & ~stallD, the head entry is removed at the clock edge.
- Push and pop in the same cycle are legal at any count. The count changes by push minus pop.
- Head presentation: validD = (count != 0). pcD/instrD come from the read pointer. The pointer is 1 bit and wraps 1→0. The write pointer wraps the same way.
- Flush takes priority over every other event in its cycle:
  - FIFO is emptied: count=0, pointers=0, validD=0 next cycle.
  - Any push in the flush cycle is dropped.
  - WAIT & ~data_ok → DROP. WAIT & data_ok → IDLE, data dropped.
  - IDLE & fire & ~data_ok → DROP. This request was issued with the stale pcF.
  - IDLE & fire & data_ok → IDLE, data dropped.
  - DROP stays DROP unless data_ok, which goes to IDLE.
- A pop that is pending during a flush has no further effect.

## Timing
- Reset values:
  - state IDLE, count 0, pointers 0.
  - validD 0, pcD RESET_PC, instrD 0, stall_fetch 0.
  - perf counters 0.
- Latency: a push at edge N makes the entry visible on validD/pcD/instrD in cycle N+1 when the FIFO was empty.
- Throughput:
  - Same-cycle addr_ok+data_ok: 1 instruction per cycle while decode drains.
  - Otherwise: 1 instruction per 2 cycles.
- stall_fetch rises in the cycle after a fire that leaves state WAIT, or after count reaches 2.
- stall_fetch falls in the cycle after the data_ok that returns to IDLE with count < 2.
- Reset asserted mid-request forces IDLE. A data_ok for that request arriving later is ignored because it arrives in IDLE; the bus is reset with the core.

## Configuration
- FDBUF_PERF_EN defined:
  - perf_fetched increments on every accepted push.
  - perf_bubbles increments on every cycle with validD=0 and resetn=1.
  - Both are 32-bit and wrap 0xffff_ffff→0.
- FDBUF_PERF_EN undefined: both ports are present and tied to 0, and no counter flops exist.

## Test plan
- Zero-wait bus (addr_ok=data_ok=1, data=pc^32'h1234), stallD=0, 4 requests from 0xbfc00000 → validD=1 from cycle 2, pcD/instrD step 0xbfc00000/…04/…08/…0c one per cycle, stall_fetch stays 0.
- 1-cycle data latency → stall_fetch=1 in every cycle after a fire, one instruction every 2 cycles, pcD matches the latched pend_pc.
- stallD=1 held with zero-wait bus → count reaches 2, stall_fetch=1, head stays pc 0xbfc00000. Release stallD → entries 0xbfc00000 then …04 drain in order; the write-pointer wrap is exercised.
- flush in WAIT with data_ok 3 cycles later → state DROP, that data never appears on instrD; the next request returns normally with its own pc.
- flush in the same cycle as push and pop with count=2 → validD=0 next cycle, count=0, no entry from the push cycle appears.
- With FDBUF_PERF_EN: 10 pushes and 5 empty cycles → perf_fetched=10, perf_bubbles=5. Without the macro → both read 0.
